// File: rtl/scpu_bus_target_if.sv
// Sound Z80 bus bundle: address/data/strobes from the CPU wrapper, read data,
// wait and interrupt back to it.
interface scpu_bus_target_if;
  logic [15:0] scpu_ab;
  logic [7:0]  scpu_dout;
  logic [7:0]  scpu_din;
  logic        scpu_rd;
  logic        scpu_wr;
  logic        scpu_mreq;
  logic        scpu_io;
  logic        scpu_wait;
  logic        irq_n;

  modport master (
    output scpu_ab, scpu_dout, scpu_rd, scpu_wr, scpu_mreq, scpu_io,
    input  scpu_din, scpu_wait, irq_n
  );

  modport slave (
    input  scpu_ab, scpu_dout, scpu_rd, scpu_wr, scpu_mreq, scpu_io,
    output scpu_din, scpu_wait, irq_n
  );
endinterface

// File: rtl/scpu_bus_target.sv
// Sound CPU bus responder: ROM fetch through an external request/valid
// handshake, internal work RAM, and the command/reply mailbox with its IRQ.
module scpu_bus_target #(
  parameter int RAM_AW  = 11,
  parameter int IRQ_LEN = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  scpu_bus_target_if.slave  bus,
  output logic [14:0]       rom_addr,
  output logic              rom_req,
  input  logic [7:0]        rom_data,
  input  logic              rom_valid,
  input  logic              cmd_wr,
  input  logic [7:0]        cmd_data,
  output logic [7:0]        reply_data,
  output logic              reply_valid,
  input  logic              reply_ack,
  output logic [1:0]        dbg_state_o
);

  // ROM handshake: rom_req is a level raised with the fetch and held until the
  // cycle rom_valid pulses; rom_data is only sampled in that pulse cycle, and
  // only while a fetch is outstanding (a stray or late pulse is ignored).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } rom_state_e;

  localparam int CW = $clog2(IRQ_LEN + 1);

  rom_state_e  state_q, state_d;
  logic [14:0] rom_addr_q;
  logic [7:0]  rom_data_q;

  logic rom_dec, ram_dec, port0, port1;
  logic rom_cyc, rom_cyc_q, rom_rise;
  logic mem_wr, mem_wr_q, ram_we;
  logic io_rd, io_rd_q, io_rd_rise;
  logic io_wr, io_wr_q, io_wr_rise;

  logic [7:0]  ram_q [2**RAM_AW];
  logic [7:0]  ram_rdata_q;

  logic [7:0]  cmd_latch_q;
  logic        cmd_pending_q, overrun_q;
  logic [CW-1:0] irq_cnt_q;
  logic [7:0]  reply_data_q;
  logic        reply_valid_q;
  logic [7:0]  io_val, io_rdata_q;

  assign rom_dec = ~bus.scpu_ab[15];
  assign ram_dec = bus.scpu_ab[15] && (bus.scpu_ab[14:RAM_AW] == '0);
  assign port0   = (bus.scpu_ab[7:0] == 8'h00);
  assign port1   = (bus.scpu_ab[7:0] == 8'h01);

  // Rising edges are gated by reset so nothing starts while it is held.
  assign rom_cyc    = bus.scpu_mreq & bus.scpu_rd & rom_dec;
  assign rom_rise   = rom_cyc & ~rom_cyc_q & ~reset;
  assign mem_wr     = bus.scpu_mreq & bus.scpu_wr;
  assign ram_we     = mem_wr & ~mem_wr_q & ram_dec & ~reset;
  assign io_rd      = bus.scpu_io & bus.scpu_rd;
  assign io_wr      = bus.scpu_io & bus.scpu_wr;
  assign io_rd_rise = io_rd & ~io_rd_q & ~reset;
  assign io_wr_rise = io_wr & ~io_wr_q & ~reset;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      rom_cyc_q  <= 1'b0;
      mem_wr_q   <= 1'b0;
      io_rd_q    <= 1'b0;
      io_wr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rom_cyc_q <= rom_cyc;
      mem_wr_q  <= mem_wr;
      io_rd_q   <= io_rd;
      io_wr_q   <= io_wr;
      if (state_q == ST_IDLE && rom_rise) rom_addr_q <= bus.scpu_ab[14:0];
      if (state_q == ST_FETCH && rom_valid) rom_data_q <= rom_data;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rom_rise) state_d = ST_FETCH;
      ST_FETCH: if (rom_valid) state_d = ST_HOLD;
      ST_HOLD:  if (!bus.scpu_rd) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request and wait assert combinationally on the fetch edge itself.
  always_comb begin
    rom_req       = 1'b0;
    bus.scpu_wait = 1'b0;
    rom_addr      = rom_addr_q;
    case (state_q)
      ST_IDLE: if (rom_rise) begin
        rom_req       = 1'b1;
        bus.scpu_wait = 1'b1;
        rom_addr      = bus.scpu_ab[14:0];
      end
      ST_FETCH: begin
        rom_req       = 1'b1;
        bus.scpu_wait = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

  always_ff @(posedge clk_sys) begin
    if (ram_we) ram_q[bus.scpu_ab[RAM_AW-1:0]] <= bus.scpu_dout;
    ram_rdata_q <= ram_q[bus.scpu_ab[RAM_AW-1:0]];
  end

  always_comb begin
    io_val = 8'hFF;
    if (port0)      io_val = cmd_latch_q;
    else if (port1) io_val = {6'b0, overrun_q, cmd_pending_q};
  end

  // A command arriving with a port-0 read keeps pending set and leaves overrun.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cmd_latch_q   <= '0;
      cmd_pending_q <= 1'b0;
      overrun_q     <= 1'b0;
      irq_cnt_q     <= '0;
      reply_data_q  <= '0;
      reply_valid_q <= 1'b0;
      io_rdata_q    <= 8'hFF;
    end else begin
      if (io_rd_rise) io_rdata_q <= io_val;
      if (cmd_wr) begin
        cmd_latch_q   <= cmd_data;
        cmd_pending_q <= 1'b1;
        irq_cnt_q     <= CW'(IRQ_LEN);
        if (cmd_pending_q && !(io_rd_rise && port0)) overrun_q <= 1'b1;
      end else begin
        if (io_rd_rise && port0) begin
          cmd_pending_q <= 1'b0;
          overrun_q     <= 1'b0;
        end
        if (irq_cnt_q != '0) irq_cnt_q <= irq_cnt_q - CW'(1);
      end
      if (io_wr_rise && port0) begin
        reply_data_q  <= bus.scpu_dout;
        reply_valid_q <= 1'b1;
      end else if (reply_ack) begin
        reply_valid_q <= 1'b0;
      end
    end
  end

  assign bus.irq_n = (irq_cnt_q == '0);
  assign reply_data  = reply_data_q;
  assign reply_valid = reply_valid_q;

  always_comb begin
    bus.scpu_din = 8'hFF;
    if (reset) begin
      bus.scpu_din = 8'hFF;
    end else if (state_q == ST_HOLD) begin
      bus.scpu_din = rom_data_q;
    end else if (bus.scpu_mreq && bus.scpu_rd && ram_dec) begin
      bus.scpu_din = ram_rdata_q;
    end else if (io_rd) begin
      bus.scpu_din = io_rd_rise ? io_val : io_rdata_q;
    end
  end

endmodule

// File: tb/tb_scpu_bus_target.sv
// Directed bench for scpu_bus_target: a vector table for mailbox, reply and
// RAM traffic, plus hand-written sequences for ROM fetch, IRQ timing and reset.
module tb_scpu_bus_target;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [14:0] rom_addr;
  logic        rom_req;
  logic [7:0]  rom_data;
  logic        rom_valid;
  logic        cmd_wr;
  logic [7:0]  cmd_data;
  logic [7:0]  reply_data;
  logic        reply_valid;
  logic        reply_ack;
  logic [1:0]  dbg_state;

  scpu_bus_target_if bus ();

  scpu_bus_target #(.RAM_AW(11), .IRQ_LEN(16)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .bus         (bus),
    .rom_addr    (rom_addr),
    .rom_req     (rom_req),
    .rom_data    (rom_data),
    .rom_valid   (rom_valid),
    .cmd_wr      (cmd_wr),
    .cmd_data    (cmd_data),
    .reply_data  (reply_data),
    .reply_valid (reply_valid),
    .reply_ack   (reply_ack),
    .dbg_state_o (dbg_state)
  );

  always #5 clk_sys = ~clk_sys;

  int n_vec = 0;
  int n_err = 0;

  // ctl = {rd, wr, mreq, io}
  localparam logic [3:0] C_IDLE = 4'b0000;
  localparam logic [3:0] C_IOR  = 4'b1001;
  localparam logic [3:0] C_IOW  = 4'b0101;
  localparam logic [3:0] C_MR   = 4'b1010;
  localparam logic [3:0] C_MW   = 4'b0110;
  localparam logic [3:0] C_IACK = 4'b0001;

  typedef struct {
    logic [15:0] ab;
    logic [7:0]  dout;
    logic [3:0]  ctl;
    logic        cw;
    logic [7:0]  cd;
    logic        ack;
    logic [7:0]  e_din;
    logic [7:0]  e_rdata;
    logic        e_rvalid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [15:0] ab, input logic [7:0] dout,
                              input logic [3:0] ctl, input logic cw,
                              input logic [7:0] cd, input logic ack,
                              input logic [7:0] e_din, input logic [7:0] e_rdata,
                              input logic e_rvalid);
    vec_t v;
    v.ab = ab; v.dout = dout; v.ctl = ctl; v.cw = cw; v.cd = cd; v.ack = ack;
    v.e_din = e_din; v.e_rdata = e_rdata; v.e_rvalid = e_rvalid;
    return v;
  endfunction

  task automatic step();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_bus(input logic [15:0] ab, input logic [7:0] dout, input logic [3:0] ctl);
    bus.scpu_ab   = ab;
    bus.scpu_dout = dout;
    {bus.scpu_rd, bus.scpu_wr, bus.scpu_mreq, bus.scpu_io} = ctl;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int lows;
    int rises;
    logic prev_irq;

    reset = 1'b1;
    rom_data = 8'h00; rom_valid = 1'b0;
    cmd_wr = 1'b0; cmd_data = 8'h00; reply_ack = 1'b0;
    drive_bus(16'h0000, 8'h00, C_IDLE);
    @(negedge clk_sys);
    repeat (3) step();

    // Reset values, sampled while reset is still held.
    chk("rst_din", bus.scpu_din, 8'hFF);
    chk("rst_wait", bus.scpu_wait, 1'b0);
    chk("rst_irq_n", bus.irq_n, 1'b1);
    chk("rst_rom_req", rom_req, 1'b0);
    chk("rst_rom_addr", rom_addr, 15'h0000);
    chk("rst_reply", {reply_valid, reply_data}, 9'h000);
    chk("rst_state", dbg_state, 2'd0);
    reset = 1'b0;
    step();
    drive_bus(16'h0001, 8'h00, C_IOR);
    step();
    chk("rst_status", bus.scpu_din, 8'h00);
    drive_bus(16'h0000, 8'h00, C_IDLE);
    step();

    // ROM fetch of 0x1234, data returned 20 cycles after the request.
    drive_bus(16'h1234, 8'h00, C_MR);
    #1;
    chk("fetch_req_edge", {rom_req, bus.scpu_wait}, 2'b11);
    chk("fetch_addr", rom_addr, 15'h1234);
    hi = 0;
    repeat (19) begin
      step();
      if (rom_req && bus.scpu_wait && rom_addr == 15'h1234) hi++;
    end
    chk("fetch_stall_cycles", hi, 19);
    rom_valid = 1'b1; rom_data = 8'h5A;
    #1;
    chk("fetch_req_valid_cycle", {rom_req, bus.scpu_wait}, 2'b11);
    step();
    rom_valid = 1'b0; rom_data = 8'h00;
    chk("fetch_release", {rom_req, bus.scpu_wait}, 2'b00);
    chk("fetch_din", bus.scpu_din, 8'h5A);
    step(); step();
    chk("fetch_din_hold", bus.scpu_din, 8'h5A);
    drive_bus(16'h1234, 8'h00, C_IDLE);
    step();
    chk("fetch_done_din", bus.scpu_din, 8'hFF);
    chk("fetch_done_state", dbg_state, 2'd0);

    // Command 0x3C: IRQ pulse length.
    cmd_wr = 1'b1; cmd_data = 8'h3C;
    step();
    cmd_wr = 1'b0;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.irq_n) lows++;
      step();
    end
    chk("irq_len", lows, 16);

    // Mailbox, overrun, reply, IO misc and RAM vectors.
    vecs.push_back(mk(16'h0001, 8'h00, C_IOR,  0, 8'h00, 0, 8'h01, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IOR,  0, 8'h00, 0, 8'h3C, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(16'h0001, 8'h00, C_IOR,  0, 8'h00, 0, 8'h00, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 1, 8'h11, 0, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 1, 8'h22, 0, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(16'h0001, 8'h00, C_IOR,  0, 8'h00, 0, 8'h03, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IOR,  0, 8'h00, 0, 8'h22, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(16'h0001, 8'h00, C_IOR,  0, 8'h00, 0, 8'h00, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 1, 8'h44, 0, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IOR,  1, 8'h55, 0, 8'h44, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(16'h0001, 8'h00, C_IOR,  0, 8'h00, 0, 8'h01, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IOR,  0, 8'h00, 0, 8'h55, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h00, 0));
    vecs.push_back(mk(16'h0000, 8'h77, C_IOW,  0, 8'h00, 0, 8'hFF, 8'h77, 1));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h77, 1));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 1, 8'hFF, 8'h77, 0));
    vecs.push_back(mk(16'h0000, 8'h88, C_IOW,  0, 8'h00, 1, 8'hFF, 8'h88, 1));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h88, 1));
    vecs.push_back(mk(16'h0005, 8'h99, C_IOW,  0, 8'h00, 0, 8'hFF, 8'h88, 1));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h88, 1));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 1, 8'hFF, 8'h88, 0));
    vecs.push_back(mk(16'h0007, 8'h00, C_IOR,  0, 8'h00, 0, 8'hFF, 8'h88, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h88, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IACK, 0, 8'h00, 0, 8'hFF, 8'h88, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h88, 0));
    vecs.push_back(mk(16'h0001, 8'h00, C_IOR,  0, 8'h00, 0, 8'h00, 8'h88, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h88, 0));
    vecs.push_back(mk(16'h8010, 8'hA5, C_MW,   0, 8'h00, 0, 8'hFF, 8'h88, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h88, 0));
    vecs.push_back(mk(16'h87FF, 8'h5C, C_MW,   0, 8'h00, 0, 8'hFF, 8'h88, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h88, 0));
    vecs.push_back(mk(16'h8010, 8'h00, C_MR,   0, 8'h00, 0, 8'hA5, 8'h88, 0));
    vecs.push_back(mk(16'h87FF, 8'h00, C_MR,   0, 8'h00, 0, 8'h5C, 8'h88, 0));
    vecs.push_back(mk(16'h9000, 8'h00, C_MR,   0, 8'h00, 0, 8'hFF, 8'h88, 0));
    vecs.push_back(mk(16'h8800, 8'h00, C_MR,   0, 8'h00, 0, 8'hFF, 8'h88, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h88, 0));
    vecs.push_back(mk(16'h0100, 8'hEE, C_MW,   0, 8'h00, 0, 8'hFF, 8'h88, 0));
    vecs.push_back(mk(16'h0000, 8'h00, C_IDLE, 0, 8'h00, 0, 8'hFF, 8'h88, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive_bus(vecs[i].ab, vecs[i].dout, vecs[i].ctl);
      cmd_wr    = vecs[i].cw;
      cmd_data  = vecs[i].cd;
      reply_ack = vecs[i].ack;
      step();
      chk($sformatf("vec%0d_din", i), bus.scpu_din, vecs[i].e_din);
      chk($sformatf("vec%0d_reply", i), {reply_valid, reply_data},
          {vecs[i].e_rvalid, vecs[i].e_rdata});
      chk($sformatf("vec%0d_rom_idle", i), {rom_req, bus.scpu_wait}, 2'b00);
    end
    cmd_wr = 1'b0; reply_ack = 1'b0;
    drive_bus(16'h0000, 8'h00, C_IDLE);
    repeat (20) step();

    // A second command mid-pulse reloads the counter without a new falling edge.
    cmd_wr = 1'b1; cmd_data = 8'h66;
    step();
    cmd_wr = 1'b0;
    lows = 0; rises = 0; prev_irq = bus.irq_n;
    for (int i = 0; i < 40; i++) begin
      if (!bus.irq_n) lows++;
      if (bus.irq_n && !prev_irq) rises++;
      prev_irq = bus.irq_n;
      cmd_wr = (i == 5);
      cmd_data = 8'h67;
      step();
    end
    cmd_wr = 1'b0;
    chk("irq_ext_len", lows, 22);
    chk("irq_ext_pulses", rises, 1);

    // Reset in the middle of a fetch, then a late rom_valid, then a clean fetch.
    drive_bus(16'h0ABC, 8'h00, C_MR);
    repeat (3) step();
    chk("midrst_stalled", {rom_req, bus.scpu_wait}, 2'b11);
    reset = 1'b1;
    drive_bus(16'h0ABC, 8'h00, C_IDLE);
    step();
    chk("midrst_release", {rom_req, bus.scpu_wait}, 2'b00);
    reset = 1'b0;
    rom_valid = 1'b1; rom_data = 8'hEE;
    step();
    rom_valid = 1'b0; rom_data = 8'h00;
    chk("late_valid_state", dbg_state, 2'd0);
    chk("late_valid_bus", {rom_req, bus.scpu_wait, bus.scpu_din}, {2'b00, 8'hFF});
    step();
    drive_bus(16'h0ABC, 8'h00, C_MR);
    #1;
    chk("refetch_req", {rom_req, bus.scpu_wait, rom_addr}, {2'b11, 15'h0ABC});
    step(); step();
    rom_valid = 1'b1; rom_data = 8'h42;
    step();
    rom_valid = 1'b0; rom_data = 8'h00;
    chk("refetch_din", {bus.scpu_wait, bus.scpu_din}, {1'b0, 8'h42});
    drive_bus(16'h0000, 8'h00, C_IDLE);
    step();
    chk("refetch_done", dbg_state, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scpu_bus_target.md
Name: scpu_bus_target

Overview:
- Bus responder for the sound Z80. Decodes its address, read, write, memory-request and I/O strobes, and serves each cycle.
- Serves three things:
  - ROM fetch through an external memory request/valid handshake, stalling the CPU with wait.
  - Internal work RAM.
  - Command/reply mailbox to the main CPU, which also generates the sound CPU interrupt request line.
- Sits between the sound CPU wrapper and the SDRAM arbiter / main CPU latch logic.

Parameters:
- RAM_AW, 11, work RAM address width (2 KB at 0x8000–0x87FF).
- IRQ_LEN, 16, clk_sys cycles irq_n is held low per new command.

Ports:
- clk_sys  input  1  system clock
- reset  input  1  synchronous, active-high reset
- scpu_ab  input  16  CPU address
- scpu_dout  input  8  CPU write data
- scpu_din  output  8  read data to CPU
- scpu_rd  input  1  CPU read strobe, active high
- scpu_wr  input  1  CPU write strobe, active high
- scpu_mreq  input  1  memory cycle, active high
- scpu_io  input  1  I/O cycle, active high
- scpu_wait  output  1  stall request to CPU, active high
- irq_n  output  1  interrupt request, active-low pulse
- rom_addr  output  15  ROM byte address
- rom_req  output  1  ROM fetch request, level
- rom_data  input  8  ROM data
- rom_valid  input  1  one-cycle pulse, rom_data valid
- cmd_wr  input  1  main CPU writes command, one-cycle pulse
- cmd_data  input  8  command byte
- reply_data  output  8  last reply byte from sound CPU
- reply_valid  output  1  reply unread by main CPU
- reply_ack  input  1  main CPU read reply, one-cycle pulse

Behaviour:
- Reset values:
  - scpu_din=0xFF, scpu_wait=0, irq_n=1, rom_req=0, rom_addr=0.
  - reply_data=0, reply_valid=0.
  - Command latch=0, cmd_pending=0, overrun=0, ROM FSM in IDLE.
- Reset mid-fetch aborts the fetch: rom_req drops the next cycle. A rom_valid arriving afterwards is ignored.
- Memory decode (mreq & rd):
  - 0x0000–0x7FFF: ROM.
  - 0x8000–0x87FF: RAM.
  - Anything else reads 0xFF.
- Memory writes: only RAM accepts them; all other memory writes are ignored.
- ROM FSM states:
  - IDLE: a rising edge of (mreq & rd & ROM decode) latches rom_addr=scpu_ab[14:0], sets rom_req=1 and scpu_wait=1 in the same cycle (combinational on that edge), then goes to FETCH.
  - FETCH: on rom_valid, capture rom_data into the ROM data register, clear rom_req and scpu_wait, go to HOLD.
  - HOLD: scpu_din = captured byte until rd falls, then go to IDLE.
- ROM wait rules:
  - scpu_wait stays high throughout FETCH, with no timeout.
  - The wait release registered on rom_valid may lag rom_valid by at most 1 cycle.
- RAM:
  - Synchronous block RAM, address = scpu_ab[RAM_AW-1:0].
  - Read data appears on scpu_din 1 clk_sys after the address is presented. No wait is generated, because the CPU cen period is at least 8 clk_sys.
  - Write is performed on the cycle where mreq & wr rises.
- I/O decode uses scpu_ab[7:0] and acts on the rising edge of (io & rd) or (io & wr):
  - Read port 0x00: returns the command latch and clears cmd_pending and overrun.
  - Read port 0x01: returns {6'b0, overrun, cmd_pending}.
  - Write port 0x00: reply_data=scpu_dout, reply_valid=1.
  - Other ports: read 0xFF, writes ignored.
- I/O with neither rd nor wr (interrupt acknowledge) has no effect.
- Command path:
  - cmd_wr: latch cmd_data, set cmd_pending, load the IRQ counter with IRQ_LEN.
  - irq_n=0 while the counter is nonzero.
  - cmd_wr while cmd_pending=1 sets overrun and overwrites the latch.
- Simultaneous events:
  - cmd_wr and a port-0x00 read edge in the same cycle: the new command wins. cmd_pending=1 and overrun is unchanged; the CPU reads the old latch value.
  - reply_ack in the same cycle as a port-0x00 write: reply_valid stays 1.
  - reply_ack alone clears reply_valid.
- cmd_wr during an active IRQ pulse reloads the counter (pulse is extended, no second falling edge).

Test Plan:
- ROM fetch: CPU reads 0x1234; rom_valid returns 0x5A after 20 cycles -> rom_addr=0x1234, rom_req and scpu_wait high exactly until the rom_valid cycle, scpu_din=0x5A until rd falls.
- RAM: write 0xA5 to 0x8010, read it back -> 0xA5 one clk after the address; read 0x9000 -> 0xFF; write to 0x0100 leaves ROM handshake idle.
- Mailbox: cmd_wr 0x3C -> irq_n low 16 cycles, status 0x01; port 0x00 read -> 0x3C, status 0x00.
- Overrun: two cmd_wr (0x11, 0x22) without a read -> status 0x03, port 0x00 returns 0x22; same-cycle cmd_wr plus port read -> pending remains 1.
- Reply: sound CPU writes 0x77 to port 0x00 -> reply_data=0x77, reply_valid=1; reply_ack clears it; coincident write+ack keeps valid=1.
- Reset mid-FETCH: assert reset during wait -> next cycle scpu_wait=0, rom_req=0; a late rom_valid changes nothing; the next ROM read fetches normally.
